// File: rtl/bnn_pkg.sv
// Shared types and bus encodings for the BNN layer sequencer.
package bnn_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INI,
      S_ACC,
      S_POOL,
      S_NORM,
      S_NORM8,
      S_DRAIN1,
      S_DRAIN2,
      S_CAPT
   } seq_state_t;

   localparam logic [31:0] BNN_ADDR_INI  = 32'h1000;
   localparam logic [31:0] BNN_ADDR_POOL = 32'h1004;

   localparam logic [3:0] BE_ACC   = 4'hF;
   localparam logic [3:0] BE_NORM  = 4'b1011;
   localparam logic [3:0] BE_NORM8 = 4'b1001;
   localparam logic [3:0] BE_NOP   = 4'b1101;

endpackage

// File: rtl/bnn_bus_mux.sv
// Selects between zero-riscy data-port requests and sequencer commands on the
// shared memory bus; the CPU only owns the bus while the sequencer is idle.
module bnn_bus_mux (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel_cpu,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_be,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        seq_b_req,
   input  logic [31:0] seq_addr,
   input  logic [3:0]  seq_be,
   input  logic [31:0] seq_wdata,
   output logic        m_b_req,
   output logic        m_p_req,
   output logic        m_p_we,
   output logic [3:0]  m_p_be,
   output logic [31:0] m_p_addr,
   output logic [31:0] m_p_wdata,
   input  logic [31:0] m_p_rdata
);

   logic rvalid_q;

   always_comb begin
      cpu_gnt   = sel_cpu;
      m_p_req   = sel_cpu & cpu_req;
      m_b_req   = sel_cpu ? 1'b0 : seq_b_req;
      m_p_we    = sel_cpu ? cpu_we : 1'b0;
      m_p_be    = sel_cpu ? cpu_be : seq_be;
      m_p_addr  = sel_cpu ? cpu_addr : seq_addr;
      m_p_wdata = sel_cpu ? cpu_wdata : seq_wdata;
   end

   // A request held off while busy is only answered once it is actually granted.
   always_ff @(posedge clk) begin
      if (!rst_n) rvalid_q <= 1'b0;
      else        rvalid_q <= sel_cpu & cpu_req;
   end

   assign cpu_rvalid = rvalid_q;
   assign cpu_rdata  = m_p_rdata;

endmodule

// File: rtl/bnn_seq.sv
// BNN layer sequencer: issues INI/ACC/POOL/NORM/NORM8 commands to the memory
// block, captures the core activation bits, and arbitrates the CPU port.
//
// state   | meaning
// IDLE    | CPU owns the bus, waiting for start
// INI     | load bias into accumulators
// ACC     | one weight row per accepted activation word
// POOL    | close pool window, reload bias
// NORM    | threshold row
// NORM8   | optional second norm row
// DRAIN1  | NOP, core pipeline stage 1
// DRAIN2  | NOP, core pipeline stage 2 (sets bnn_en_1)
// CAPT    | sample activation bits, pulse res_valid
module bnn_seq
   import bnn_pkg::*;
#(
   parameter int AW = 10,
   parameter int CW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] cfg_n_words,
   input  logic [2:0]    cfg_pool,
   input  logic [AW-1:0] cfg_param_base,
   input  logic [AW-1:0] cfg_norm_addr,
   input  logic          cfg_norm8,
   input  logic [15:0]   cfg_bias,
   input  logic          act_valid,
   output logic          act_ready,
   input  logic [31:0]   act_data,
   output logic          res_valid,
   output logic [31:0]   res_data,
   output logic          busy,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [3:0]    cpu_be,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [31:0]   cpu_rdata,
   output logic          m_b_req,
   output logic          m_p_req,
   output logic          m_p_we,
   output logic [3:0]    m_p_be,
   output logic [31:0]   m_p_addr,
   output logic [31:0]   m_p_wdata,
   input  logic [31:0]   m_p_rdata
);

   seq_state_t    state, state_nx;
   logic [CW-1:0] word_cnt;
   logic [2:0]    pool_cnt;
   logic [CW-1:0] n_words_q;
   logic [2:0]    pool_last_q;
   logic [AW-1:0] base_q;
   logic [AW-1:0] norm_q;
   logic          norm8_q;
   logic [15:0]   bias_q;
   logic [31:0]   res_q;

   logic          seq_b_req;
   logic [31:0]   seq_addr;
   logic [3:0]    seq_be;
   logic [31:0]   seq_wdata;
   logic          sel_cpu;

   function automatic logic [31:0] row_addr(input logic [AW-1:0] row);
      return {{(30-AW){1'b0}}, row, 2'b00};
   endfunction

   always_comb begin
      state_nx  = state;
      seq_b_req = 1'b0;
      seq_addr  = '0;
      seq_be    = BE_NOP;
      seq_wdata = '0;
      act_ready = 1'b0;
      res_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_INI;
         end
         S_INI: begin
            seq_b_req = 1'b1;
            seq_addr  = BNN_ADDR_INI;
            seq_be    = BE_ACC;
            seq_wdata = {16'h0, bias_q};
            state_nx  = (n_words_q == '0) ? S_POOL : S_ACC;
         end
         S_ACC: begin
            act_ready = 1'b1;
            seq_b_req = act_valid;
            seq_addr  = row_addr(base_q + AW'(word_cnt));
            seq_be    = BE_ACC;
            seq_wdata = act_data;
            if (act_valid && (word_cnt == n_words_q - CW'(1))) state_nx = S_POOL;
         end
         S_POOL: begin
            seq_b_req = 1'b1;
            seq_addr  = BNN_ADDR_POOL;
            seq_be    = BE_ACC;
            seq_wdata = {16'h0, bias_q};
            // An empty window has no ACC phase, so further windows are bare POOLs.
            if (pool_cnt == pool_last_q)  state_nx = S_NORM;
            else if (n_words_q == '0)     state_nx = S_POOL;
            else                          state_nx = S_ACC;
         end
         S_NORM: begin
            seq_b_req = 1'b1;
            seq_addr  = row_addr(norm_q);
            seq_be    = BE_NORM;
            state_nx  = norm8_q ? S_NORM8 : S_DRAIN1;
         end
         S_NORM8: begin
            seq_b_req = 1'b1;
            seq_addr  = row_addr(norm_q + AW'(1));
            seq_be    = BE_NORM8;
            state_nx  = S_DRAIN1;
         end
         S_DRAIN1: begin
            seq_b_req = 1'b1;
            state_nx  = S_DRAIN2;
         end
         S_DRAIN2: begin
            seq_b_req = 1'b1;
            state_nx  = S_CAPT;
         end
         S_CAPT: begin
            res_valid = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         word_cnt    <= '0;
         pool_cnt    <= '0;
         n_words_q   <= '0;
         pool_last_q <= '0;
         base_q      <= '0;
         norm_q      <= '0;
         norm8_q     <= 1'b0;
         bias_q      <= '0;
         res_q       <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_words_q   <= cfg_n_words;
                  pool_last_q <= (cfg_pool == 3'd0) ? 3'd0 : cfg_pool - 3'd1;
                  base_q      <= cfg_param_base;
                  norm_q      <= cfg_norm_addr;
                  norm8_q     <= cfg_norm8;
                  bias_q      <= cfg_bias;
               end
            end
            S_INI: begin
               word_cnt <= '0;
               pool_cnt <= '0;
            end
            S_ACC: begin
               if (act_valid) word_cnt <= word_cnt + CW'(1);
            end
            S_POOL: begin
               word_cnt <= '0;
               pool_cnt <= pool_cnt + 3'd1;
            end
            S_CAPT: begin
               res_q <= m_p_rdata;
            end
            default: ;
         endcase
      end
   end

   // Result is presented in the capture cycle itself and held afterwards.
   assign res_data = (state == S_CAPT) ? m_p_rdata : res_q;
   assign busy     = (state != S_IDLE);
   assign sel_cpu  = (state == S_IDLE);

   bnn_bus_mux u_bus_mux (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel_cpu   (sel_cpu),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_be    (cpu_be),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .seq_b_req (seq_b_req),
      .seq_addr  (seq_addr),
      .seq_be    (seq_be),
      .seq_wdata (seq_wdata),
      .m_b_req   (m_b_req),
      .m_p_req   (m_p_req),
      .m_p_we    (m_p_we),
      .m_p_be    (m_p_be),
      .m_p_addr  (m_p_addr),
      .m_p_wdata (m_p_wdata),
      .m_p_rdata (m_p_rdata)
   );

endmodule

// File: doc/bnn_seq.md
Name: bnn_seq

Overview:
- Layer sequencer and bus arbiter in front of zeroriscy_mem_bnn.
- Takes a layer configuration and a stream of activation words, then issues the INI / ACC / POOL / NORM / NORM8 command sequence over the shared b_req/p_* bus. After the sequence it captures the 32 core activation bits.
- Muxes zero-riscy data-port requests onto the same bus and stalls the CPU while a layer is running.

Parameters:
- AW, 10, parameter-RAM row address width (ram_addr).
- CW, 10, word-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; latches cfg_* and starts a layer; ignored while busy
- cfg_n_words  in  CW  ACC words per pool window
- cfg_pool  in  3  pool windows; 0 is treated as 1
- cfg_param_base  in  AW  first weight row
- cfg_norm_addr  in  AW  norm row; NORM8 uses cfg_norm_addr+1
- cfg_norm8  in  1  also issue NORM8
- cfg_bias  in  16  INI value, driven on p_wdata[15:0]
- act_valid / act_ready / act_data  in / out / in  1 / 1 / 32  activation stream
- res_valid  out  1  one-cycle pulse with result
- res_data  out  32  activation bits, bit g = core g
- busy  out  1
- cpu_req, cpu_we  in  1 each
- cpu_be  in  4
- cpu_addr, cpu_wdata  in  32 each
- cpu_gnt  out  1
- cpu_rvalid  out  1
- cpu_rdata  out  32
- m_b_req, m_p_req, m_p_we  out  1 each
- m_p_be  out  4
- m_p_addr, m_p_wdata  out  32 each
- m_p_rdata  in  32

Behaviour:
- Reset (rst_n=0 at posedge):
  - state IDLE; all counters 0.
  - busy=0, res_valid=0, res_data=0, cpu_rvalid=0, m_b_req=0.
  - Reset mid-layer abandons the layer; no res_valid.
- Bus encodings (m_p_we=0 and m_p_req=0 for every command):
  - ACC: addr={19'b0,0,row[9:0],2'b00}, be=4'hF, wdata=act_data.
  - NORM: addr bit12=0, row field=cfg_norm_addr, be=4'b1011.
  - NORM8: addr bit12=0, row field=cfg_norm_addr+1, be=4'b1001.
  - NOP: addr=0, be=4'b1101.
  - INI: addr=32'h1000, wdata={16'h0,cfg_bias}.
  - POOL: addr=32'h1004, wdata={16'h0,cfg_bias}. POOL reloads acc with the bias.
- IDLE:
  - CPU passthrough: m_p_*=cpu_*, m_p_req=cpu_req, cpu_gnt=1, m_b_req=0.
  - cpu_rvalid=registered(cpu_req), cpu_rdata=m_p_rdata.
  - On start, go to INI; cpu_gnt=0 from the next cycle.
- Busy (every state other than IDLE): cpu_gnt=0, m_p_req=0. A CPU request arriving while busy is held off, not dropped.
- INI: one cycle. Then go to ACC, or to POOL if cfg_n_words==0. word_cnt=0, pool_cnt=0.
- ACC:
  - act_ready=1 in this state only; m_b_req=act_valid.
  - No act_valid means a bubble cycle with m_b_req=0 (cores see a no-op).
  - On each handshake: row=cfg_param_base+word_cnt, word_cnt++. At word_cnt==cfg_n_words-1, go to POOL.
- POOL: one cycle. word_cnt=0, pool_cnt++. If pool_cnt==cfg_pool-1, go to NORM, else back to ACC.
- NORM: one cycle. Go to NORM8 if cfg_norm8, else to DRAIN1.
- NORM8: one cycle. Go to DRAIN1.
- DRAIN1 and DRAIN2: one NOP each. They cover the 2-stage core pipeline; the DRAIN2 NOP sets bnn_en_1 in the memory block.
- CAPT:
  - m_b_req=0. Sample res_data<=m_p_rdata, pulse res_valid.
  - Go to IDLE; busy=0 in the next cycle.
- Timing:
  - Latency from last command (NORM or NORM8) to res_valid: 3 cycles.
  - Because CAPT has m_b_req=0, the first CPU read after IDLE returns RAM data, not b_rdata.
- Width rules:
  - Row address addition wraps modulo 2^AW.
  - cfg_* are latched at start, so changes while busy have no effect.
  - start in the same cycle as cpu_req in IDLE: the CPU access is granted that cycle, and the sequencer starts next cycle.

Decomposition:
- Package bnn_pkg holds:
  - state enum seq_state_t;
  - constants BNN_ADDR_INI=32'h1000, BNN_ADDR_POOL=32'h1004;
  - BE_ACC=4'hF, BE_NORM=4'b1011, BE_NORM8=4'b1001, BE_NOP=4'b1101.
- One sub-module, bnn_bus_mux: a combinational select between the CPU request and the sequencer command, plus the registered cpu_rvalid.

Test Plan:
- Reset check: hold rst_n=0 mid-ACC for 1 cycle -> next cycle busy=0, m_b_req=0, no res_valid, and cpu_gnt=1.
- Basic layer: n_words=3, pool=1, base=5, norm=100, norm8=0, act always valid.
  - Expected command order: INI, ACC rows 5,6,7, POOL, NORM row 100, NOP, NOP.
  - res_valid at cycle 9 after start, with res_data = the m_p_rdata of that cycle.
- Act stalls: deassert act_valid for 2 cycles mid-ACC -> m_b_req=0 in those cycles, row sequence unchanged, result delayed by 2 cycles.
- Pooling: pool=2, n_words=2, norm8=1.
  - Expected command order: INI, ACC 5,6, POOL, ACC 5,6, POOL, NORM, NORM8 (row 101), NOP, NOP.
  - Activations consumed: 4.
- CPU contention:
  - cpu_req held during a layer -> cpu_gnt=0 until IDLE, then granted; cpu_rvalid follows one cycle later.
  - start while busy -> ignored.
- Edge cases:
  - n_words=0 -> INI then POOL directly.
  - cfg_pool=0 -> behaves as pool=1.
  - base=1022, n_words=3 -> rows 1022, 1023, 0.
